fpu_ctrl: RTL and testbench

Command sequencer that initiates operations on the floating-point add/sub unit and plays the initiator role of its start/idle handshake. Holds the two operand registers R1 and R2 and exposes them to the FPU. Accepts a stream of load/arithmetic/store commands, pulses the FPU start lines and waits for completion. Writes results back into R1 and emits stored words on an output port.

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/fpu_ctrl_watchdog.sv | 30 +++
 rtl/fpu_ctrl.sv | 157 +++++++++++++++
 tb/tb_fpu_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU command sequencer: word layout, canonical
// zero, command opcodes and the sequencer state encoding.
package fpu_pkg;

  localparam int unsigned E_W    = 7;
  localparam int unsigned M_W    = 15;
  localparam int unsigned WORD_W = 23;

  // Packed word {s, e[6:0], m[14:0]}; zero is the smallest exponent with m=1.0.
  localparam logic [WORD_W-1:0] FPU_ZERO = 23'h204000;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LD1 = 3'd1;
  localparam logic [2:0] OP_LD2 = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_ST  = 3'd5;
  localparam logic [2:0] OP_XCH = 3'd6;
  localparam logic [2:0] OP_CLR = 3'd7;

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

endpackage

// File: rtl/fpu_ctrl_watchdog.sv
// Cycle watchdog for the FPU wait states.
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart the count (wins over en)
//   en         : count this cycle
//   expired    : high on the TIMEOUT-th enabled cycle after a clear
module fpu_ctrl_watchdog #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fpu_ctrl.sv
// Command sequencer for the floating-point add/sub unit.
//   cmd_*      : command stream (valid/ready), opcode and load data
//   fpu_add/sub: one-cycle start pulses to the FPU
//   fpu_r1_*/fpu_r2_* : operand registers R1/R2 exposed to the FPU
//   fpu_res_*, fpu_idle: FPU result and idle flag
//   out_*      : stored-word output (valid/ready)
//   err        : sticky FPU timeout flag
module fpu_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [WORD_W-1:0] cmd_data,
  output logic              fpu_add,
  output logic              fpu_sub,
  output logic              fpu_r1_s,
  output logic [E_W-1:0]    fpu_r1_e,
  output logic [M_W-1:0]    fpu_r1_m,
  output logic              fpu_r2_s,
  output logic [E_W-1:0]    fpu_r2_e,
  output logic [M_W-1:0]    fpu_r2_m,
  input  logic              fpu_res_s,
  input  logic [E_W-1:0]    fpu_res_e,
  input  logic [M_W-1:0]    fpu_res_m,
  input  logic              fpu_idle,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic              err
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] r1_q, r2_q;
  logic [WORD_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              err_q;
  logic              sub_q;
  logic              st_stall;
  logic              accept;
  logic              capture;
  logic              timeout;
  logic              wd_clr, wd_en, wd_expired;

  assign {fpu_r1_s, fpu_r1_e, fpu_r1_m} = r1_q;
  assign {fpu_r2_s, fpu_r2_e, fpu_r2_m} = r2_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

  // A store cannot overwrite a word the consumer has not taken yet.
  assign st_stall = (cmd_op == OP_ST) && out_valid_q && !out_ready;
  assign accept   = cmd_valid && cmd_ready;

  fpu_ctrl_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    fpu_add   = 1'b0;
    fpu_sub   = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      S_SYNC: begin
        if (fpu_idle) state_d = S_IDLE;
      end
      S_IDLE: begin
        cmd_ready = !st_stall;
        if (cmd_valid && !st_stall && (cmd_op == OP_ADD || cmd_op == OP_SUB))
          state_d = S_ISSUE;
      end
      S_ISSUE: begin
        fpu_add = !sub_q;
        fpu_sub = sub_q;
        wd_clr  = 1'b1;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        wd_en = 1'b1;
        if (!fpu_idle) begin
          wd_clr  = 1'b1;
          state_d = S_WAIT_DONE;
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        wd_en = 1'b1;
        if (fpu_idle) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q        <= FPU_ZERO;
      r2_q        <= FPU_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      sub_q       <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        case (cmd_op)
          OP_LD1: r1_q <= cmd_data;
          OP_LD2: r2_q <= cmd_data;
          OP_XCH: begin
            r1_q <= r2_q;
            r2_q <= r1_q;
          end
          OP_CLR: r1_q <= FPU_ZERO;
          OP_ST: begin
            // Overrides the clear above when a handshake coincides.
            out_data_q  <= r1_q;
            out_valid_q <= 1'b1;
          end
          OP_ADD: sub_q <= 1'b0;
          OP_SUB: sub_q <= 1'b1;
          default: ;
        endcase
      end
      if (capture) r1_q <= {fpu_res_s, fpu_res_e, fpu_res_m};
      if (timeout) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_ctrl.sv
// Scoreboard bench for fpu_ctrl with a behavioural FPU model attached.
module tb_fpu_ctrl;
  import fpu_pkg::*;

  localparam int unsigned TIMEOUT = 31;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = OP_NOP;
  logic [22:0] cmd_data = '0;
  logic        fpu_add, fpu_sub;
  logic        fpu_r1_s, fpu_r2_s;
  logic [6:0]  fpu_r1_e, fpu_r2_e;
  logic [14:0] fpu_r1_m, fpu_r2_m;
  logic        out_valid;
  logic [22:0] out_data;
  logic        out_ready = 1'b0;
  logic        err;

  logic        stub_idle;
  logic [22:0] sres;
  logic [22:0] dut_r1, dut_r2;

  int total = 0;
  int bad = 0;
  int n_add = 0, n_sub = 0;
  int add_pulses = 0, sub_pulses = 0;
  int ready_mode = 0;     // 0 random, 1 hold low, 2 hold high
  bit hang = 1'b0;        // FPU ignores start pulses and stays idle
  logic [22:0] m_r1 = FPU_ZERO, m_r2 = FPU_ZERO;
  logic [22:0] exp_q[$];

  assign dut_r1 = {fpu_r1_s, fpu_r1_e, fpu_r1_m};
  assign dut_r2 = {fpu_r2_s, fpu_r2_e, fpu_r2_m};

  always #5 clk = ~clk;

  fpu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .fpu_add   (fpu_add),
    .fpu_sub   (fpu_sub),
    .fpu_r1_s  (fpu_r1_s),
    .fpu_r1_e  (fpu_r1_e),
    .fpu_r1_m  (fpu_r1_m),
    .fpu_r2_s  (fpu_r2_s),
    .fpu_r2_e  (fpu_r2_e),
    .fpu_r2_m  (fpu_r2_m),
    .fpu_res_s (sres[22]),
    .fpu_res_e (sres[21:15]),
    .fpu_res_m (sres[14:0]),
    .fpu_idle  (stub_idle),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value-level add/sub: align to the larger exponent (truncating), add as
  // signed integers, renormalise; canonical zero stands for 0.
  function automatic logic [22:0] fp_op(input logic [22:0] a, input logic [22:0] b, input bit sub);
    longint ma, mb, sum, mag;
    int ea, eb, emax, e;
    bit sa, sb, sg;
    sa = a[22];
    sb = b[22] ^ sub;
    ea = int'($signed(a[21:15]));
    eb = int'($signed(b[21:15]));
    ma = longint'(a[14:0]);
    mb = longint'(b[14:0]);
    if (a == FPU_ZERO) begin ma = 0; ea = eb; end
    if (b == FPU_ZERO) begin mb = 0; eb = ea; end
    emax = (ea > eb) ? ea : eb;
    ma = (emax - ea > 30) ? 0 : (ma >> (emax - ea));
    mb = (emax - eb > 30) ? 0 : (mb >> (emax - eb));
    sum = (sa ? -ma : ma) + (sb ? -mb : mb);
    if (sum == 0) return FPU_ZERO;
    sg = (sum < 0);
    mag = sg ? -sum : sum;
    e = emax;
    while (mag >= 32768) begin mag = mag >> 1; e++; end
    while (mag < 16384) begin mag = mag << 1; e--; end
    return {sg, 7'(e), 15'(mag)};
  endfunction

  function automatic logic [22:0] rand_word();
    int e;
    e = int'($urandom_range(12, 0)) - 6;
    return {1'($urandom % 2), 7'(e), 1'b1, 14'($urandom)};
  endfunction

  // Behavioural FPU: idle undefined (low) right after reset, samples the
  // start pulse, drops idle two cycles after the pulse, busy 3..9 more cycles.
  typedef enum {B_BOOT, B_IDLE, B_PEND, B_BUSY} stub_t;
  stub_t       st;
  int          scnt;
  logic [22:0] pend_res;

  always @(posedge clk) begin
    if (reset) begin
      st        <= B_BOOT;
      scnt      <= 2;
      stub_idle <= 1'b0;
      sres      <= 23'($urandom);
    end else begin
      case (st)
        B_BOOT: if (scnt == 0) begin st <= B_IDLE; stub_idle <= 1'b1; end
                else scnt <= scnt - 1;
        B_IDLE: if ((fpu_add || fpu_sub) && !hang) begin
          pend_res <= fp_op(dut_r1, dut_r2, fpu_sub);
          st <= B_PEND;
        end
        B_PEND: begin
          stub_idle <= 1'b0;
          scnt <= int'($urandom_range(9, 3));
          sres <= 23'($urandom);
          st <= B_BUSY;
        end
        B_BUSY: if (scnt == 0) begin
          stub_idle <= 1'b1;
          sres <= pend_res;
          st <= B_IDLE;
        end else begin
          scnt <= scnt - 1;
          sres <= 23'($urandom);
        end
      endcase
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: out_ready = 1'b0;
        2: out_ready = 1'b1;
        default: out_ready = ($urandom % 4) != 0;
      endcase
    end
  end

  // Monitor: output words against the scoreboard, start-pulse shape.
  logic prev_add = 1'b0, prev_sub = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_add <= 1'b0;
      prev_sub <= 1'b0;
    end else begin
      if (fpu_add && fpu_sub) chk("both_pulses", 32'd1, 32'd0);
      if (fpu_add && prev_add) chk("add_width", 32'd2, 32'd1);
      if (fpu_sub && prev_sub) chk("sub_width", 32'd2, 32'd1);
      if (fpu_add) add_pulses++;
      if (fpu_sub) sub_pulses++;
      prev_add <= fpu_add;
      prev_sub <= fpu_sub;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 32'(out_data), 32'hFFFFFFFF);
        else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1.
  task automatic send(input logic [2:0] op, input logic [22:0] data, input bit do_check);
    int n;
    logic [22:0] t;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin n++; @(negedge clk); end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      cmd_op = OP_NOP;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = OP_NOP;
    case (op)
      OP_LD1: m_r1 = data;
      OP_LD2: m_r2 = data;
      OP_XCH: begin t = m_r1; m_r1 = m_r2; m_r2 = t; end
      OP_CLR: m_r1 = FPU_ZERO;
      OP_ST:  exp_q.push_back(m_r1);
      OP_ADD, OP_SUB: begin
        if (op == OP_ADD) n_add++; else n_sub++;
        if (!hang) m_r1 = fp_op(m_r1, m_r2, op == OP_SUB);
      end
      default: ;
    endcase
    if (do_check) begin
      @(negedge clk);
      if (op == OP_ADD || op == OP_SUB) begin
        chk("start_pulse", 32'({fpu_add, fpu_sub}), (op == OP_ADD) ? 32'd2 : 32'd1);
        n = 0;
        while (!cmd_ready && n < 100) begin n++; @(negedge clk); end
        chk("op_done", 32'(cmd_ready), 32'd1);
        chk("r1_result", 32'(dut_r1), 32'(m_r1));
      end else begin
        chk("r1", 32'(dut_r1), 32'(m_r1));
        chk("r2", 32'(dut_r2), 32'(m_r2));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = OP_NOP;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_r1", 32'(dut_r1), 32'(FPU_ZERO));
    chk("rst_r2", 32'(dut_r2), 32'(FPU_ZERO));
    m_r1 = FPU_ZERO;
    m_r2 = FPU_ZERO;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("sync_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    ready_mode = 2;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin n++; @(negedge clk); end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bit stall_ok;
    logic [2:0] op;
    int r;

    do_reset();

    ready_mode = 0;
    send(OP_ST, '0, 1'b1);

    send(OP_LD1, 23'h004000, 1'b1);
    send(OP_LD2, 23'h004000, 1'b1);
    send(OP_ADD, '0, 1'b1);
    chk("add_1_1", 32'(dut_r1), 32'h00C000);
    send(OP_ST, '0, 1'b1);

    send(OP_LD1, 23'h006000, 1'b1);
    send(OP_LD2, 23'h004000, 1'b1);
    send(OP_ADD, '0, 1'b1);
    chk("add_1p5_1", 32'(dut_r1), 32'h00D000);
    send(OP_ST, '0, 1'b1);

    send(OP_LD1, 23'h004000, 1'b1);
    send(OP_LD2, 23'h004000, 1'b1);
    send(OP_SUB, '0, 1'b1);
    chk("sub_1_1", 32'(dut_r1), 32'h204000);
    send(OP_ST, '0, 1'b1);

    // Exchange, then a store that must wait for the consumer.
    drain();
    send(OP_LD1, 23'h006000, 1'b1);
    send(OP_LD2, 23'h004000, 1'b1);
    send(OP_XCH, '0, 1'b1);
    ready_mode = 1;
    send(OP_ST, '0, 1'b1);
    send(OP_LD1, 23'h00E000, 1'b1);
    cmd_valid = 1'b1;
    cmd_op = OP_ST;
    stall_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (cmd_ready) stall_ok = 1'b0;
    end
    chk("st_stall", 32'(stall_ok), 32'd1);
    chk("stall_out_data", 32'(out_data), 32'h004000);
    ready_mode = 2;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin n++; @(negedge clk); end
    chk("stall_release", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = OP_NOP;
    exp_q.push_back(m_r1);
    @(negedge clk);
    chk("st_reload", 32'(out_data), 32'h00E000);
    chk("st_reload_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Random command stream.
    ready_mode = 0;
    send(OP_LD1, rand_word(), 1'b0);
    send(OP_LD2, rand_word(), 1'b0);
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom % 16);
      case (r)
        0:          op = OP_NOP;
        1, 2, 3:    op = OP_LD1;
        4, 5:       op = OP_LD2;
        6, 7:       op = OP_ADD;
        8, 9:       op = OP_SUB;
        13:         op = OP_XCH;
        14:         op = OP_CLR;
        default:    op = OP_ST;
      endcase
      send(op, rand_word(), 1'($urandom % 2));
    end

    // FPU never leaves idle: watchdog must fire, R1 untouched.
    drain();
    ready_mode = 0;
    hang = 1'b1;
    send(OP_ADD, '0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 100);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_cycles", 32'((n >= int'(TIMEOUT) + 1) && (n <= int'(TIMEOUT) + 4)), 32'd1);
    n = 0;
    while (!cmd_ready && n < 10) begin n++; @(negedge clk); end
    chk("timeout_ready", 32'(cmd_ready), 32'd1);
    chk("timeout_r1", 32'(dut_r1), 32'(m_r1));
    @(posedge clk); #1;
    hang = 1'b0;
    send(OP_ST, '0, 1'b1);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset while an ADD is in flight.
    drain();
    send(OP_LD1, rand_word(), 1'b0);
    send(OP_ADD, '0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    do_reset();
    chk("post_reset_err", 32'(err), 32'd0);
    ready_mode = 0;
    send(OP_ST, '0, 1'b1);
    send(OP_LD2, 23'h006000, 1'b1);
    send(OP_ADD, '0, 1'b1);
    send(OP_ST, '0, 1'b1);

    drain();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("add_pulses", 32'(add_pulses), 32'(n_add));
    chk("sub_pulses", 32'(sub_pulses), 32'(n_sub));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

endmodule
